// File: rtl/conv_enc_frame_ctrl_if.sv
// Info-bit stream into conv_enc_frame_ctrl: the source drives valid/bit, the sequencer returns ready.
interface conv_enc_frame_ctrl_if;
  logic s_valid;
  logic s_bit;
  logic s_ready;

  modport master (output s_valid, output s_bit, input s_ready);
  modport slave  (input s_valid, input s_bit, output s_ready);
endinterface

// File: rtl/conv_enc_frame_ctrl.sv
// Frame sequencer for conv_encoder_1_2: seed, stream info bits, append M tail zeros.
// Define CONV_ENC_TAILBITE_EN to add the frame buffer and tail-biting LOAD/SEED/REPLAY path.
module conv_enc_frame_ctrl #(
  parameter int K       = 4,
  parameter int M       = K - 1,
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_tailbite,
  conv_enc_frame_ctrl_if.slave   s_if,
  output logic                   enc_seed_load,
  output logic [M-1:0]           enc_seed_value,
  output logic                   enc_in_valid,
  output logic                   enc_in_bit,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (K < 2 || M != K - 1) begin : g_param_check
    $error("conv_enc_frame_ctrl: need K >= 2 and M == K-1");
  end

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEED, ST_DATA, ST_TAIL, ST_DONE, ST_LOAD, ST_REPLAY
  } state_t;

  state_t            r_state, w_nxt;
  logic [LEN_W-1:0]  r_len, r_cnt, w_cnt_inc;
  logic              r_bad;
  logic              r_s_ready, r_seed_load, r_in_valid, r_in_bit, r_busy, r_done, r_err;
  logic [M-1:0]      r_seed_value;
  logic              w_s_ready_n, w_seed_load_n, w_in_valid_n, w_in_bit_n;
  logic              w_busy_n, w_done_n, w_err_n;
  logic [M-1:0]      w_seed_value_n, w_seed;
  logic              w_hs, w_last, w_tail_last, w_adv, w_start_bad;
  logic              w_tb_req, w_tb_mode, w_rep_bit;

  assign w_hs        = s_if.s_valid && r_s_ready;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_last      = (w_cnt_inc == r_len);
  assign w_tail_last = (r_cnt == LEN_W'(M - 1));
  assign w_adv       = w_hs || (r_state == ST_TAIL) || (r_state == ST_REPLAY);
  assign w_start_bad = (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN)) ||
                       (w_tb_req && (cfg_len < LEN_W'(M)));

`ifdef CONV_ENC_TAILBITE_EN
  logic               r_tb;
  logic [MAX_LEN-1:0] r_buf;

  always_ff @(posedge clk) begin
    if (rst)
      r_tb <= 1'b0;
    else if (r_state == ST_IDLE && start)
      r_tb <= cfg_tailbite;
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && w_hs)
      r_buf[r_cnt[IDX_W-1:0]] <= s_if.s_bit;
  end

  assign w_tb_req  = cfg_tailbite;
  assign w_tb_mode = r_tb;
  assign w_rep_bit = r_buf[r_cnt[IDX_W-1:0]];

  // Seed = last M buffered bits, newest in the MSB.
  always_comb begin
    w_seed = '0;
    for (int unsigned j = 0; j < M; j++)
      w_seed[j] = r_buf[IDX_W'(r_len - LEN_W'(M) + LEN_W'(j))];
  end
`else
  logic w_unused_tb;
  assign w_unused_tb = cfg_tailbite;
  assign w_tb_req    = 1'b0;
  assign w_tb_mode   = 1'b0;
  assign w_rep_bit   = 1'b0;
  assign w_seed      = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_nxt = w_start_bad ? ST_DONE : (w_tb_req ? ST_LOAD : ST_SEED);
      ST_LOAD:   if (w_hs && w_last) w_nxt = ST_SEED;
      ST_SEED:   w_nxt = w_tb_mode ? ST_REPLAY : ST_DATA;
      ST_DATA:   if (w_hs && w_last) w_nxt = ST_TAIL;
      ST_TAIL:   if (w_tail_last) w_nxt = ST_DONE;
      ST_REPLAY: if (w_last) w_nxt = ST_DONE;
      ST_DONE:   w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; s_ready follows the next state so it drops on the last bit.
  always_comb begin
    w_busy_n       = (r_state == ST_IDLE) ? start : (r_state != ST_DONE);
    w_s_ready_n    = (w_nxt == ST_DATA) || (w_nxt == ST_LOAD);
    w_seed_load_n  = (r_state == ST_SEED);
    w_seed_value_n = (r_state == ST_SEED) ? w_seed : '0;
    w_in_valid_n   = 1'b0;
    w_in_bit_n     = 1'b0;
    case (r_state)
      ST_DATA:   if (w_hs) begin w_in_valid_n = 1'b1; w_in_bit_n = s_if.s_bit; end
      ST_TAIL:   w_in_valid_n = 1'b1;
      ST_REPLAY: begin w_in_valid_n = 1'b1; w_in_bit_n = w_rep_bit; end
      default:   ;
    endcase
    w_done_n = (r_state == ST_DONE);
    w_err_n  = (r_state == ST_DONE) && r_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len        <= '0;
      r_cnt        <= '0;
      r_bad        <= 1'b0;
      r_s_ready    <= 1'b0;
      r_seed_load  <= 1'b0;
      r_seed_value <= '0;
      r_in_valid   <= 1'b0;
      r_in_bit     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_len <= cfg_len;
        r_bad <= w_start_bad;
      end
      if (r_state != w_nxt)
        r_cnt <= '0;
      else if (w_adv)
        r_cnt <= w_cnt_inc;
      r_s_ready    <= w_s_ready_n;
      r_seed_load  <= w_seed_load_n;
      r_seed_value <= w_seed_value_n;
      r_in_valid   <= w_in_valid_n;
      r_in_bit     <= w_in_bit_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
      r_err        <= w_err_n;
    end
  end

  assign s_if.s_ready   = r_s_ready;
  assign enc_seed_load  = r_seed_load;
  assign enc_seed_value = r_seed_value;
  assign enc_in_valid   = r_in_valid;
  assign enc_in_bit     = r_in_bit;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_conv_enc_frame_ctrl.sv
// Directed bench for conv_enc_frame_ctrl with a (7,5) K=3 encoder model on the enc_* outputs.
module tb_conv_enc_frame_ctrl;
  localparam int K       = 3;
  localparam int M       = 2;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_tailbite = 1'b0;
  logic             enc_seed_load, enc_in_valid, enc_in_bit, busy, done, err;
  logic [M-1:0]     enc_seed_value;

  conv_enc_frame_ctrl_if sif();

  conv_enc_frame_ctrl #(.K(K), .M(M), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_tailbite(cfg_tailbite),
    .s_if(sif), .enc_seed_load(enc_seed_load), .enc_seed_value(enc_seed_value),
    .enc_in_valid(enc_in_valid), .enc_in_bit(enc_in_bit), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: encoder model and event log, sampled on the falling edge.
  int         cyc = 0;
  logic [1:0] m_state = '0;
  logic [1:0] last_seed = '0;
  int         n_seed = 0, n_done = 0, done_cyc = 0;
  logic       last_err = 1'b0, order_bad = 1'b0, busy_at_done = 1'b0;
  int         q_cyc[$];
  logic [1:0] q_sym[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enc_seed_load) begin
      m_state   = enc_seed_value;
      last_seed = enc_seed_value;
      n_seed++;
    end
    if (enc_in_valid) begin
      if (n_seed == 0) order_bad = 1'b1;
      q_sym.push_back({enc_in_bit ^ m_state[1] ^ m_state[0], enc_in_bit ^ m_state[0]});
      q_cyc.push_back(cyc);
      m_state = {enc_in_bit, m_state[1]};
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      last_err = err;
      if (busy) busy_at_done = 1'b1;
    end
  end

  typedef struct {
    int          len;
    bit          tbm;
    logic [15:0] bits;
    int          gap_at;
    bit          poke;
    bit          exp_err;
    int          exp_nv;
    logic [31:0] exp_syms;
    logic [1:0]  exp_state;
    logic [1:0]  exp_seed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int len, input bit tbm, input logic [15:0] bits,
                              input int gap_at, input bit poke, input bit exp_err,
                              input int exp_nv, input logic [31:0] exp_syms,
                              input logic [1:0] exp_state, input logic [1:0] exp_seed);
    vec_t v;
    v.len = len; v.tbm = tbm; v.bits = bits; v.gap_at = gap_at; v.poke = poke;
    v.exp_err = exp_err; v.exp_nv = exp_nv; v.exp_syms = exp_syms;
    v.exp_state = exp_state; v.exp_seed = exp_seed;
    return v;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, output bit ok);
    logic acc;
    sif.s_valid = 1'b1;
    sif.s_bit   = b;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      acc = sif.s_ready;
      tick();
      if (acc) ok = 1'b1;
    end
  endtask

  task automatic clear_mon;
    n_seed = 0; n_done = 0; order_bad = 1'b0; busy_at_done = 1'b0;
    q_cyc.delete(); q_sym.delete();
  endtask

  task automatic run_frame(input int idx, input vec_t v);
    int c0;
    bit ok;
    int nv;
    clear_mon();
    start = 1'b1; cfg_len = LEN_W'(v.len); cfg_tailbite = v.tbm;
    sif.s_valid = v.exp_err; sif.s_bit = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    check($sformatf("v%0d_busy_after_start", idx), busy, 1);
    if (!v.exp_err) begin
      for (int i = 0; i < v.len; i++) begin
        if (v.gap_at >= 0 && i == v.gap_at + 1) begin
          sif.s_valid = 1'b0;
          repeat (3) tick();
        end
        if (v.poke && i == 1) begin start = 1'b1; cfg_len = LEN_W'(3); end
        send_bit(v.bits[i], ok);
        start = 1'b0;
        if (!ok) begin
          check($sformatf("v%0d_handshake_timeout", idx), 0, 1);
          break;
        end
      end
    end
    // Keep offering junk bits: none may be accepted after the last info bit.
    sif.s_valid = 1'b1; sif.s_bit = 1'b1;
    for (int t = 0; t < 100 && n_done == 0; t++) tick();
    check($sformatf("v%0d_done_seen", idx), int'(n_done != 0), 1);
    sif.s_valid = 1'b0;
    repeat (4) tick();
    nv = q_sym.size();
    check($sformatf("v%0d_done_count", idx), n_done, 1);
    check($sformatf("v%0d_err", idx), last_err, v.exp_err);
    check($sformatf("v%0d_seed_count", idx), n_seed, v.exp_err ? 0 : 1);
    check($sformatf("v%0d_valid_count", idx), nv, v.exp_nv);
    for (int i = 0; i < v.exp_nv && i < nv; i++)
      check($sformatf("v%0d_sym%0d", idx, i), q_sym[i], v.exp_syms[2*i +: 2]);
    check($sformatf("v%0d_busy_at_done", idx), busy_at_done, 0);
    check($sformatf("v%0d_valid_before_seed", idx), order_bad, 0);
    if (v.exp_err) begin
      check($sformatf("v%0d_err_done_latency", idx), done_cyc - c0, 2);
    end else begin
      check($sformatf("v%0d_end_state", idx), m_state, v.exp_state);
      check($sformatf("v%0d_seed_value", idx), last_seed, v.exp_seed);
      if (!v.tbm && nv > M)
        check($sformatf("v%0d_tail_back_to_back", idx), q_cyc[nv-1] - q_cyc[nv-1-M], M);
      if (v.tbm && nv > 1)
        check($sformatf("v%0d_replay_back_to_back", idx), q_cyc[nv-1] - q_cyc[0], nv - 1);
    end
    if (v.gap_at >= 0 && nv > v.gap_at + 1)
      check($sformatf("v%0d_gap_cycles", idx), q_cyc[v.gap_at+1] - q_cyc[v.gap_at] - 1, 3);
  endtask

  function automatic int outs_packed();
    return int'({enc_seed_load, enc_seed_value, enc_in_valid, enc_in_bit, busy, done, err, sif.s_ready});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bit ok;
    vec_t v2;
    //                 len tb bits          gap poke err nv  syms (i_n..i_0)                                       state  seed
    vecs.push_back(mk(4, 0, 16'b1101,      -1, 0,  0,  6, 32'({2'b11,2'b01,2'b01,2'b00,2'b10,2'b11}), 2'b00, 2'b00));
    vecs.push_back(mk(4, 0, 16'b1101,       1, 0,  0,  6, 32'({2'b11,2'b01,2'b01,2'b00,2'b10,2'b11}), 2'b00, 2'b00));
    vecs.push_back(mk(0, 0, 16'b0,         -1, 0,  1,  0, 32'd0,                                      2'b00, 2'b00));
    vecs.push_back(mk(9, 0, 16'b0,         -1, 0,  1,  0, 32'd0,                                      2'b00, 2'b00));
    vecs.push_back(mk(1, 0, 16'b1,         -1, 0,  0,  3, 32'({2'b11,2'b10,2'b11}),                   2'b00, 2'b00));
    vecs.push_back(mk(2, 0, 16'b11,        -1, 1,  0,  4, 32'({2'b11,2'b01,2'b01,2'b11}),             2'b00, 2'b00));
    vecs.push_back(mk(8, 0, 16'b1,         -1, 0,  0, 10, 32'({2'b11,2'b10,2'b11}),                   2'b00, 2'b00));
`ifdef CONV_ENC_TAILBITE_EN
    vecs.push_back(mk(4, 1, 16'b1101,      -1, 0,  0,  4, 32'({2'b01,2'b00,2'b01,2'b10}),             2'b11, 2'b11));
    vecs.push_back(mk(2, 1, 16'b11,        -1, 0,  0,  2, 32'({2'b10,2'b10}),                         2'b11, 2'b11));
    vecs.push_back(mk(1, 1, 16'b1,         -1, 0,  1,  0, 32'd0,                                      2'b00, 2'b00));
`else
    vecs.push_back(mk(2, 1, 16'b11,        -1, 0,  0,  4, 32'({2'b11,2'b01,2'b01,2'b11}),             2'b00, 2'b00));
`endif

    sif.s_valid = 1'b0; sif.s_bit = 1'b0;
    repeat (3) tick();
    check("reset_outputs", outs_packed(), 0);
    rst = 1'b0;
    tick();
    check("idle_outputs", outs_packed(), 0);

    for (int i = 0; i < vecs.size(); i++) run_frame(i, vecs[i]);

    // Abort in TAIL with rst, then a fresh frame must reseed from zero.
    clear_mon();
    start = 1'b1; cfg_len = LEN_W'(4); cfg_tailbite = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, ok);
      if (!ok) begin check("abort_handshake_timeout", 0, 1); break; end
    end
    sif.s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outputs_zero", outs_packed(), 0);
    repeat (5) tick();
    check("abort_no_done", n_done, 0);
    v2 = mk(2, 0, 16'b11, -1, 0, 0, 4, 32'({2'b11,2'b01,2'b01,2'b11}), 2'b00, 2'b00);
    run_frame(99, v2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
